// File: rtl/wide_add_pkg.sv
// Shared definitions for the wide_add_sequencer multi-precision adder.
// Holds the controller state encoding, default geometry and the index
// width helper used to size the word counter.
package wide_add_pkg;

    // Controller states: waiting for an operation, stepping slices, holding result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_WORDS = 4;

    // Width of the slice index counter; never narrower than one bit.
    function automatic int idx_width(input int words);
        if (words > 1) begin
            return $clog2(words);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/thirtytwo_bit_adder.sv
// Plain 32-bit ripple-carry adder slice shared by the wide add sequencer.
// Purely combinational; the sequencer registers everything around it.
module thirtytwo_bit_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic ripple_s;

    // Bit-serial carry ripple from bit 0 up to bit 31.
    always_comb begin
        sum      = '0;
        ripple_s = cin;
        for (int i = 0; i < 32; i++) begin
            sum[i]   = a[i] ^ b[i] ^ ripple_s;
            ripple_s = (a[i] & b[i]) | (ripple_s & (a[i] ^ b[i]));
        end
        cout = ripple_s;
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: adds two WORDS*WIDTH-bit operands by stepping one
// shared 32-bit adder slice over WORDS cycles, least-significant word first,
// with the carry chained through a register. Operands come in over an
// in_valid/in_ready handshake; the result, carry-out and signed overflow leave
// over an out_valid/out_ready handshake.
// Optional feature macro: WIDE_ADD_SUB_EN adds the `sub` port (a - b).
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORDS*WIDTH-1:0] a,
    input  logic [WORDS*WIDTH-1:0] b,
    input  logic                   cin,
`ifdef WIDE_ADD_SUB_EN
    input  logic                   sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDS*WIDTH-1:0] sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);

    localparam int IDXW = idx_width(WORDS);
    localparam int TOTW = WORDS * WIDTH;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    state_e            state_q, state_d;
    logic [TOTW-1:0]   a_q, a_d;
    logic [TOTW-1:0]   b_q, b_d;
    logic [TOTW-1:0]   sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [TOTW-1:0]   b_load_s;
    logic              carry_load_s;
    logic [WIDTH-1:0]  adder_a_s;
    logic [WIDTH-1:0]  adder_b_s;
    logic              adder_cin_s;
    logic [WIDTH-1:0]  adder_sum_s;
    logic              adder_cout_s;

`ifdef WIDE_ADD_SUB_EN
    // Subtraction is a + ~b + 1: invert b and force the initial carry.
    always_comb begin
        if (sub) begin
            b_load_s     = ~b;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = b;
            carry_load_s = cin;
        end
    end
`else
    // Addition only: operands and carry-in are taken as presented.
    always_comb begin
        b_load_s     = b;
        carry_load_s = cin;
    end
`endif

    // Select the current operand words for the shared slice; idle inputs are 0.
    always_comb begin
        adder_a_s   = '0;
        adder_b_s   = '0;
        adder_cin_s = 1'b0;
        if (state_q == ST_RUN) begin
            for (int w = 0; w < WORDS; w++) begin
                if (idx_q == IDXW'(w)) begin
                    adder_a_s = a_q[w*WIDTH +: WIDTH];
                    adder_b_s = b_q[w*WIDTH +: WIDTH];
                end else begin
                    adder_a_s = adder_a_s;
                end
            end
            adder_cin_s = carry_q;
        end else begin
            adder_cin_s = 1'b0;
        end
    end

    thirtytwo_bit_adder u_adder (
        .a    (adder_a_s),
        .b    (adder_b_s),
        .cin  (adder_cin_s),
        .sum  (adder_sum_s),
        .cout (adder_cout_s)
    );

    // Next-state and datapath update for the accept / run / hold sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_load_s;
                    carry_d = carry_load_s;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_q == IDXW'(w)) begin
                        sum_d[w*WIDTH +: WIDTH] = adder_sum_s;
                    end else begin
                        sum_d[w*WIDTH +: WIDTH] = sum_q[w*WIDTH +: WIDTH];
                    end
                end
                carry_d = adder_cout_s;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = adder_cout_s;
                    // Signed overflow: like-signed operands giving an opposite-signed result.
                    ovf_d   = (a_q[TOTW-1] == b_q[TOTW-1]) &&
                              (adder_sum_s[WIDTH-1] != a_q[TOTW-1]);
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (WORDS=4, WIDTH=32).
// Expected results come from plain 130-bit signed arithmetic in the bench.
module tb_wide_add_sequencer;

    localparam int WIDTH = 32;
    localparam int WORDS = 4;
    localparam int TOTW  = WIDTH * WORDS;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [TOTW-1:0] a;
    logic [TOTW-1:0] b;
    logic            cin;
`ifdef WIDE_ADD_SUB_EN
    logic            sub;
`endif
    logic            out_valid;
    logic            out_ready;
    logic [TOTW-1:0] sum;
    logic            cout;
    logic            ovf;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef WIDE_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    // Reference: a + b + cin (or a - b) as signed integers wide enough never to wrap.
    function automatic void model(input logic [TOTW-1:0] ma, input logic [TOTW-1:0] mb,
                                  input logic mc, input logic ms,
                                  output logic [TOTW-1:0] es, output logic ec, output logic eo);
        logic [TOTW+1:0] ua;
        logic [TOTW+1:0] ub;
        logic [TOTW+1:0] sa;
        logic [TOTW+1:0] sb;
        logic [TOTW+1:0] uf;
        logic [TOTW+1:0] sf;
        logic [TOTW-1:0] be;
        logic            ce;
        be = ms ? ~mb : mb;
        ce = ms ? 1'b1 : mc;
        ua = {2'b00, ma};
        ub = {2'b00, be};
        uf = ua + ub + {{(TOTW+1){1'b0}}, ce};
        sa = {{2{ma[TOTW-1]}}, ma};
        sb = {{2{be[TOTW-1]}}, be};
        sf = sa + sb + {{(TOTW+1){1'b0}}, ce};
        es = uf[TOTW-1:0];
        ec = uf[TOTW];
        // Out of signed range when the true signed sum needs more than TOTW bits.
        eo = (sf[TOTW] != sf[TOTW-1]);
    endfunction

    function automatic logic [TOTW-1:0] rand_wide(input int kind);
        logic [TOTW-1:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        case (kind)
            1: r = '1;
            2: r = '0;
            3: r = {1'b0, {(TOTW-1){1'b1}}};
            4: r = {1'b1, {(TOTW-1){1'b0}}};
            default: r = r;
        endcase
        return r;
    endfunction

    // Drive one operation through both handshakes; reports outputs and latency.
    task automatic run_op(input logic [TOTW-1:0] ra, input logic [TOTW-1:0] rb, input logic rc,
                          output logic [TOTW-1:0] os, output logic oc, output logic oo,
                          output int lat, output bit to);
        int n;
        to = 1'b0;
        a = ra;
        b = rb;
        cin = rc;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) to = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) to = 1'b1;
        os = sum;
        oc = cout;
        oo = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (sum !== '0)         begin errors++; $display("FAIL reset_sum got %h want 0", sum); end
        checks++; if (cout !== 1'b0)      begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    endtask

    task automatic test_full_ripple();
        logic [TOTW-1:0] s; logic c, o; int lat; bit to;
        run_op('1, 128'd1, 1'b0, s, c, o, lat, to);
        checks++; if (to)           begin errors++; $display("FAIL ripple_timeout got 1 want 0"); end
        checks++; if (lat != WORDS) begin errors++; $display("FAIL ripple_latency got %0d want %0d", lat, WORDS); end
        checks++; if (s !== '0)     begin errors++; $display("FAIL ripple_sum got %h want 0", s); end
        checks++; if (c !== 1'b1)   begin errors++; $display("FAIL ripple_cout got %b want 1", c); end
        checks++; if (o !== 1'b0)   begin errors++; $display("FAIL ripple_ovf got %b want 0", o); end
    endtask

    task automatic test_overflow();
        logic [TOTW-1:0] s; logic c, o; int lat; bit to;
        logic [TOTW-1:0] maxpos;
        logic [TOTW-1:0] minneg;
        maxpos = {1'b0, {(TOTW-1){1'b1}}};
        minneg = {1'b1, {(TOTW-1){1'b0}}};
        run_op(maxpos, 128'd1, 1'b0, s, c, o, lat, to);
        checks++; if (to || s !== minneg) begin errors++; $display("FAIL ovf_sum got %h want %h", s, minneg); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL ovf_cout got %b want 0", c); end
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", o); end
    endtask

    task automatic test_carry_in();
        logic [TOTW-1:0] s; logic c, o; int lat; bit to;
        run_op('0, '0, 1'b1, s, c, o, lat, to);
        checks++; if (to || s !== 128'd1) begin errors++; $display("FAIL cin_sum got %h want 1", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL cin_cout got %b want 0", c); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL cin_ovf got %b want 0", o); end
    endtask

    task automatic test_backpressure();
        logic [TOTW-1:0] a1, b1, a2, b2, e1, e2;
        logic ec1, eo1, ec2, eo2;
        int lat;
        a1 = rand_wide(0); b1 = rand_wide(0);
        a2 = rand_wide(0); b2 = rand_wide(0);
        model(a1, b1, 1'b0, 1'b0, e1, ec1, eo1);
        model(a2, b2, 1'b1, 1'b0, e2, ec2, eo2);
        a = a1; b = b1; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != WORDS) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, WORDS); end
        // Second request arrives while the first result is still being held.
        a = a2; b = b2; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (sum !== e1 || cout !== ec1 || ovf !== eo1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got sum=%h cout=%b ovf=%b rdy=%b vld=%b want sum=%h cout=%b ovf=%b rdy=0 vld=1",
                         i, sum, cout, ovf, in_ready, out_valid, e1, ec1, eo1);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_second_accept got busy=%b want 1", busy); end
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != WORDS || sum !== e2 || cout !== ec2 || ovf !== eo2) begin
            errors++; $display("FAIL bp_second_result got lat=%0d sum=%h cout=%b ovf=%b want lat=%0d sum=%h cout=%b ovf=%b",
                               lat, sum, cout, ovf, WORDS, e2, ec2, eo2); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [TOTW-1:0] s, e; logic c, o, ec, eo; int lat; bit to;
        logic [TOTW-1:0] ra, rb;
        a = rand_wide(0); b = rand_wide(0); cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_accept got busy=%b want 1", busy); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Reset arrives together with a fresh request; reset must win.
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++; $display("FAIL mid_reset got rdy=%b busy=%b vld=%b sum=%h cout=%b want 1 0 0 0 0",
                               in_ready, busy, out_valid, sum, cout); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_no_pulse got busy=%b vld=%b want 0 0", busy, out_valid); end
        ra = rand_wide(0); rb = rand_wide(0);
        model(ra, rb, 1'b0, 1'b0, e, ec, eo);
        run_op(ra, rb, 1'b0, s, c, o, lat, to);
        checks++; if (to || lat != WORDS || s !== e || c !== ec || o !== eo) begin
            errors++; $display("FAIL mid_after got lat=%0d sum=%h cout=%b ovf=%b want lat=%0d sum=%h cout=%b ovf=%b",
                               lat, s, c, o, WORDS, e, ec, eo); end
    endtask

    task automatic test_random();
        logic [TOTW-1:0] ra, rb, s, e; logic rc, rs, c, o, ec, eo; int lat; bit to;
        for (int i = 0; i < 24; i++) begin
            ra = rand_wide($urandom_range(0, 4));
            rb = rand_wide($urandom_range(0, 4));
            rc = 1'($urandom_range(0, 1));
            rs = 1'b0;
`ifdef WIDE_ADD_SUB_EN
            rs = 1'($urandom_range(0, 1));
            sub = rs;
`endif
            model(ra, rb, rc, rs, e, ec, eo);
            run_op(ra, rb, rc, s, c, o, lat, to);
            checks++;
            if (to || lat != WORDS || s !== e || c !== ec || o !== eo) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h cin=%b sub=%b got lat=%0d sum=%h cout=%b ovf=%b want lat=%0d sum=%h cout=%b ovf=%b",
                         i, ra, rb, rc, rs, lat, s, c, o, WORDS, e, ec, eo);
            end
        end
`ifdef WIDE_ADD_SUB_EN
        sub = 1'b0;
`endif
    endtask

    task automatic test_back_to_back();
        logic [TOTW-1:0] s, e; logic c, o, ec, eo; int lat; bit to;
        logic [TOTW-1:0] ra, rb;
        for (int i = 0; i < 2; i++) begin
            ra = rand_wide(0); rb = rand_wide(0);
            model(ra, rb, 1'b0, 1'b0, e, ec, eo);
            run_op(ra, rb, 1'b0, s, c, o, lat, to);
            checks++; if (to || s !== e || c !== ec) begin
                errors++; $display("FAIL b2b_result_%0d got sum=%h cout=%b want sum=%h cout=%b", i, s, c, e, ec); end
            checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL b2b_ready_%0d got rdy=%b busy=%b want 1 0", i, in_ready, busy); end
        end
    endtask

`ifdef WIDE_ADD_SUB_EN
    task automatic test_subtract();
        logic [TOTW-1:0] s; logic c, o; int lat; bit to;
        sub = 1'b1;
        run_op('0, 128'd1, 1'b0, s, c, o, lat, to);
        checks++; if (to || s !== '1 || c !== 1'b0 || o !== 1'b0) begin
            errors++; $display("FAIL sub_0m1 got sum=%h cout=%b ovf=%b want all-ones 0 0", s, c, o); end
        run_op(128'd5, 128'd3, 1'b0, s, c, o, lat, to);
        checks++; if (to || s !== 128'd2 || c !== 1'b1) begin
            errors++; $display("FAIL sub_5m3 got sum=%h cout=%b want 2 1", s, c); end
        sub = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef WIDE_ADD_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_full_ripple();
        test_overflow();
        test_carry_in();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
`ifdef WIDE_ADD_SUB_EN
        test_subtract();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
